// File: rtl/experiment_sequencer_if.sv
// Signal bundle between the experiment sequencer, its host side and the experiment wrapper.
// The master modport is the sequencer's view; the slave modport is the host/wrapper view.
interface experiment_sequencer_if;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_data;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        exp_commit;
  logic [31:0] exp_command;
  logic [31:0] exp_data_in;
  logic [31:0] exp_data_out;

  modport master (
    input  start, abort, op_valid, op_data, res_ready, exp_data_out,
    output busy, done, op_ready, res_valid, res_data, exp_commit, exp_command, exp_data_in
  );

  modport slave (
    output start, abort, op_valid, op_data, res_ready, exp_data_out,
    input  busy, done, op_ready, res_valid, res_data, exp_commit, exp_command, exp_data_in
  );
endinterface

// File: rtl/experiment_sequencer.sv
// Drives one experiment run through the wrapper command port: write operands, let the
// experiment run, read results back and stream them to the host. All outputs registered.
module experiment_sequencer #(
  parameter int OPERAND_COUNT = 4,
  parameter int RESULT_COUNT  = 4,
  parameter int RUN_CYCLES    = 8,
  parameter int READ_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  experiment_sequencer_if.master bus
);

  localparam int OW = $clog2(OPERAND_COUNT) + 1;
  localparam int RW = $clog2(RESULT_COUNT) + 1;
  localparam int CW = $clog2(RUN_CYCLES) + 1;
  localparam int LW = $clog2(READ_LATENCY) + 1;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_READ_CMD,
    S_READ_WAIT,
    S_RESULT,
    S_DONE
  } state_t;

  state_t        r_state,     w_next_state;
  logic [OW-1:0] r_idx,       w_idx;
  logic [RW-1:0] r_ridx,      w_ridx;
  logic [CW-1:0] r_run_cnt,   w_run_cnt;
  logic [LW-1:0] r_wait_cnt,  w_wait_cnt;
  logic          r_op_ready,  w_op_ready;
  logic          r_commit,    w_commit;
  logic [31:0]   r_command,   w_command;
  logic [31:0]   r_data_in,   w_data_in;
  logic          r_res_valid, w_res_valid;
  logic [31:0]   r_res_data,  w_res_data;
  logic          r_busy,      w_busy;
  logic          r_done,      w_done;

  function automatic logic [31:0] make_cmd(input logic [1:0] op, input logic [15:0] idx);
    return {op, 14'd0, idx};
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    w_next_state = r_state;
    w_idx        = r_idx;
    w_ridx       = r_ridx;
    w_run_cnt    = r_run_cnt;
    w_wait_cnt   = r_wait_cnt;
    w_op_ready   = 1'b0;
    w_commit     = 1'b0;
    w_command    = '0;
    w_data_in    = r_data_in;
    w_res_valid  = r_res_valid;
    w_res_data   = r_res_data;
    w_done       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = S_LOAD;
          w_idx        = '0;
          w_ridx       = '0;
          w_op_ready   = 1'b1;
        end
      end
      S_LOAD: begin
        w_op_ready = 1'b1;
        if (r_op_ready && bus.op_valid) begin
          w_commit  = 1'b1;
          w_command = make_cmd(OP_WRITE, 16'(r_idx));
          w_data_in = bus.op_data;
          w_idx     = r_idx + OW'(1);
          if (r_idx == OW'(OPERAND_COUNT - 1)) begin
            w_next_state = S_RUN;
            w_op_ready   = 1'b0;
            w_run_cnt    = '0;
          end
        end
      end
      S_RUN: begin
        // The cycle carrying the last write commit counts as run cycle 0.
        if (r_run_cnt == CW'(RUN_CYCLES - 1)) begin
          w_next_state = S_READ_CMD;
          w_ridx       = '0;
          w_commit     = 1'b1;
          w_command    = make_cmd(OP_READ, 16'd0);
        end else begin
          w_run_cnt = r_run_cnt + CW'(1);
        end
      end
      S_READ_CMD: begin
        w_next_state = S_READ_WAIT;
        w_wait_cnt   = LW'(1);
      end
      S_READ_WAIT: begin
        if (r_wait_cnt == LW'(READ_LATENCY)) begin
          w_res_data   = bus.exp_data_out;
          w_res_valid  = 1'b1;
          w_next_state = S_RESULT;
        end else begin
          w_wait_cnt = r_wait_cnt + LW'(1);
        end
      end
      S_RESULT: begin
        if (r_res_valid && bus.res_ready) begin
          w_res_valid = 1'b0;
          w_ridx      = r_ridx + RW'(1);
          if (r_ridx == RW'(RESULT_COUNT - 1)) begin
            w_next_state = S_DONE;
            w_done       = 1'b1;
          end else begin
            w_next_state = S_READ_CMD;
            w_commit     = 1'b1;
            w_command    = make_cmd(OP_READ, 16'(w_ridx));
          end
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    // Abort wins over every other transition, handshake or strobe in the same cycle.
    if (r_state != S_IDLE && bus.abort) begin
      w_next_state = S_IDLE;
      w_op_ready   = 1'b0;
      w_commit     = 1'b0;
      w_command    = '0;
      w_res_valid  = 1'b0;
      w_done       = 1'b0;
    end

    w_busy = (w_next_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_ridx      <= '0;
      r_run_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_op_ready  <= 1'b0;
      r_commit    <= 1'b0;
      r_command   <= '0;
      r_data_in   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
      r_state     <= w_next_state;
      r_idx       <= w_idx;
      r_ridx      <= w_ridx;
      r_run_cnt   <= w_run_cnt;
      r_wait_cnt  <= w_wait_cnt;
      r_op_ready  <= w_op_ready;
      r_commit    <= w_commit;
      r_command   <= w_command;
      r_data_in   <= w_data_in;
      r_res_valid <= w_res_valid;
      r_res_data  <= w_res_data;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.op_ready    = r_op_ready;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_data    = r_res_data;
  assign bus.exp_commit  = r_commit;
  assign bus.exp_command = r_command;
  assign bus.exp_data_in = r_data_in;

endmodule
